// File: rtl/gpio_mulcount.sv
// Memory-mapped serial multiply / popcount peripheral on the GPIO slave bus.
// Operands snapshot on start; W, L, valid and op_count commit together on the DONE cycle.
module gpio_mulcount #(
   parameter int unsigned ARG_W     = 24,
   parameter int unsigned RES_W     = 32,
   parameter logic [15:0] ADDR_A1   = 16'h0380,
   parameter logic [15:0] ADDR_A2   = 16'h0388,
   parameter logic [15:0] ADDR_W    = 16'h0390,
   parameter logic [15:0] ADDR_L    = 16'h0398,
   parameter logic [15:0] ADDR_CTRL = 16'h03A0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] saddress,
   input  logic        srd,
   input  logic        swr,
   input  logic [31:0] sdata_in,
   output logic [31:0] sdata_out,
   input  logic [31:0] gpio_in,
   input  logic        gpio_latch,
   output logic [31:0] gpio_in_s_insp,
   output logic [31:0] gpio_out
);

   localparam int unsigned ACC_W   = 2 * ARG_W;
   localparam int unsigned L_W     = $clog2(RES_W + 1);
   localparam int unsigned CNT_MAX = (ARG_W > RES_W) ? ARG_W : RES_W;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_MULT, S_COUNT, S_DONE} state_t;

   state_t             state;
   state_t             state_next;

   logic [ARG_W-1:0]   a1;
   logic [ARG_W-1:0]   a2;
   logic [ACC_W-1:0]   mcand;
   logic [ARG_W-1:0]   mplier;
   logic [ACC_W-1:0]   acc;
   logic [RES_W-1:0]   pop_sr;
   logic [L_W-1:0]     ones;
   logic [CNT_W-1:0]   bit_cnt;
   logic [RES_W-1:0]   res_w;
   logic [L_W-1:0]     res_l;
   logic               valid;
   logic               err;
   logic [15:0]        op_count;

   logic               wr_ctrl_c;
   logic               busy_c;
   logic               start_c;
   logic               mult_last_c;
   logic               count_last_c;
   logic               hi_zero_c;
   logic [ACC_W-1:0]   acc_next_c;
   logic               load_c;
   logic               mult_c;
   logic               count_c;
   logic               finish_c;
   logic [31:0]        rd_data_c;
   logic               unused_c;

   assign wr_ctrl_c    = swr && (saddress == ADDR_CTRL);
   assign busy_c       = (state != S_IDLE);
   assign start_c      = wr_ctrl_c && sdata_in[0] && !busy_c;
   assign mult_last_c  = (bit_cnt == CNT_W'(ARG_W - 1));
   assign count_last_c = (bit_cnt == CNT_W'(RES_W - 1));
   assign acc_next_c   = acc + (mplier[0] ? mcand : '0);
   assign gpio_out     = {16'h0, op_count};
   assign unused_c     = ^sdata_in;

   // Product bits above the stored width decide overflow; none exist when the result fits.
   if (ACC_W > RES_W) begin : g_hi
      assign hi_zero_c = (acc[ACC_W-1:RES_W] == '0);
   end else begin : g_nohi
      assign hi_zero_c = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start_c)      state_next = S_MULT;
         S_MULT:  if (mult_last_c)  state_next = S_COUNT;
         S_COUNT: if (count_last_c) state_next = S_DONE;
         S_DONE:                    state_next = S_IDLE;
         default:                   state_next = S_IDLE;
      endcase
   end

   always_comb begin
      load_c   = 1'b0;
      mult_c   = 1'b0;
      count_c  = 1'b0;
      finish_c = 1'b0;
      case (state)
         S_IDLE:  load_c   = start_c;
         S_MULT:  mult_c   = 1'b1;
         S_COUNT: count_c  = 1'b1;
         S_DONE:  finish_c = 1'b1;
         default: ;
      endcase
   end

   // Shift-add multiplier, then popcount via a shifting copy of the truncated product.
   always_ff @(posedge clk) begin
      if (reset) begin
         mcand    <= '0;
         mplier   <= '0;
         acc      <= '0;
         pop_sr   <= '0;
         ones     <= '0;
         bit_cnt  <= '0;
         res_w    <= '0;
         res_l    <= '0;
         valid    <= 1'b1;
         op_count <= '0;
      end else begin
         if (load_c) begin
            mcand   <= ACC_W'(a1);
            mplier  <= a2;
            acc     <= '0;
            ones    <= '0;
            bit_cnt <= '0;
         end
         if (mult_c) begin
            acc    <= acc_next_c;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (mult_last_c) begin
               bit_cnt <= '0;
               pop_sr  <= RES_W'(acc_next_c);
            end else begin
               bit_cnt <= bit_cnt + CNT_W'(1);
            end
         end
         if (count_c) begin
            ones    <= ones + L_W'(pop_sr[0]);
            pop_sr  <= pop_sr >> 1;
            bit_cnt <= bit_cnt + CNT_W'(1);
         end
         if (finish_c) begin
            res_w    <= RES_W'(acc);
            res_l    <= ones;
            valid    <= hi_zero_c;
            op_count <= op_count + 16'd1;
         end
      end
   end

   always_comb begin
      rd_data_c = '0;
      case (saddress)
         ADDR_A1:   rd_data_c = 32'(a1);
         ADDR_A2:   rd_data_c = 32'(a2);
         ADDR_W:    rd_data_c = 32'(res_w);
         ADDR_L:    rd_data_c = 32'(res_l);
         ADDR_CTRL: rd_data_c = {28'h0, err, busy_c, !busy_c, valid};
         default:   rd_data_c = '0;
      endcase
   end

   // Bus side: operand registers, sticky error, read data and input capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         a1             <= '0;
         a2             <= '0;
         err            <= 1'b0;
         sdata_out      <= '0;
         gpio_in_s_insp <= '0;
      end else begin
         if (swr && (saddress == ADDR_A1)) a1 <= sdata_in[ARG_W-1:0];
         if (swr && (saddress == ADDR_A2)) a2 <= sdata_in[ARG_W-1:0];
         if (wr_ctrl_c) begin
            if (sdata_in[1])           err <= 1'b0;
            if (sdata_in[0] && busy_c) err <= 1'b1;
         end
         if (srd)        sdata_out      <= rd_data_c;
         if (gpio_latch) gpio_in_s_insp <= gpio_in;
      end
   end

endmodule

// File: tb/tb_gpio_mulcount.sv
// Directed bench for gpio_mulcount: default instance plus an ARG_W=8/RES_W=16 instance on a shared bus.
module tb_gpio_mulcount;

   localparam logic [15:0] A_A1   = 16'h0380;
   localparam logic [15:0] A_A2   = 16'h0388;
   localparam logic [15:0] A_W    = 16'h0390;
   localparam logic [15:0] A_L    = 16'h0398;
   localparam logic [15:0] A_CTRL = 16'h03A0;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] saddress;
   logic        srd;
   logic        swr;
   logic [31:0] sdata_in;
   logic [31:0] gpio_in;
   logic        gpio_latch;
   logic [31:0] sdata_out, gpio_in_s_insp, gpio_out;
   logic [31:0] sdata_out8, gpio_in_s_insp8, gpio_out8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   gpio_mulcount dut (
      .clk(clk), .reset(reset), .saddress(saddress), .srd(srd), .swr(swr),
      .sdata_in(sdata_in), .sdata_out(sdata_out), .gpio_in(gpio_in),
      .gpio_latch(gpio_latch), .gpio_in_s_insp(gpio_in_s_insp), .gpio_out(gpio_out)
   );

   gpio_mulcount #(.ARG_W(8), .RES_W(16)) dut8 (
      .clk(clk), .reset(reset), .saddress(saddress), .srd(srd), .swr(swr),
      .sdata_in(sdata_in), .sdata_out(sdata_out8), .gpio_in(gpio_in),
      .gpio_latch(gpio_latch), .gpio_in_s_insp(gpio_in_s_insp8), .gpio_out(gpio_out8)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic [15:0] addr, input logic [31:0] data);
      @(negedge clk);
      saddress = addr;
      sdata_in = data;
      swr      = 1'b1;
      @(negedge clk);
      swr      = 1'b0;
   endtask

   task automatic bus_read(input logic [15:0] addr);
      @(negedge clk);
      saddress = addr;
      srd      = 1'b1;
      @(negedge clk);
      srd      = 1'b0;
   endtask

   initial begin
      reset = 1'b1; saddress = '0; srd = 1'b0; swr = 1'b0; sdata_in = '0;
      gpio_in = '0; gpio_latch = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset state
      check("rst_gpio_out", gpio_out, 32'h0);
      check("rst_sdata_out", sdata_out, 32'h0);
      check("rst_insp", gpio_in_s_insp, 32'h0);
      bus_read(A_CTRL); check("rst_status", sdata_out, 32'h3);
      bus_read(A_W);    check("rst_w", sdata_out, 32'h0);
      bus_read(A_L);    check("rst_l", sdata_out, 32'h0);

      // 3*5 with exact completion timing
      bus_write(A_A1, 32'h3);
      bus_write(A_A2, 32'h5);
      bus_write(A_CTRL, 32'h1);
      repeat (56) @(negedge clk);
      check("t1_before_done", gpio_out, 32'h0);
      @(negedge clk);
      check("t1_at_done", gpio_out, 32'h1);
      bus_read(A_W);    check("t1_w", sdata_out, 32'h0000000F);
      bus_read(A_L);    check("t1_l", sdata_out, 32'h4);
      bus_read(A_CTRL); check("t1_status", sdata_out, 32'h3);

      // Overflowing product: upper bits of 0xFFFFFF^2 are lost
      bus_write(A_A1, 32'hFFFF_FFFF);
      bus_write(A_A2, 32'h00FF_FFFF);
      bus_write(A_CTRL, 32'h1);
      repeat (60) @(negedge clk);
      bus_read(A_W);    check("t2_w", sdata_out, 32'hFE000001);
      bus_read(A_L);    check("t2_l", sdata_out, 32'h8);
      bus_read(A_CTRL); check("t2_status", sdata_out, 32'h2);
      check("t2_gpio_out", gpio_out, 32'h2);

      // Start while busy sets sticky err, one completion only, then clear err
      bus_write(A_A1, 32'h3);
      bus_write(A_A2, 32'h5);
      bus_write(A_CTRL, 32'h1);
      repeat (8) @(negedge clk);
      bus_read(A_CTRL);     check("t3_busy", sdata_out, 32'h4);
      bus_write(A_CTRL, 32'h1);
      bus_read(A_CTRL);     check("t3_busy_err", sdata_out, 32'hC);
      repeat (60) @(negedge clk);
      bus_read(A_CTRL);     check("t3_done_err", sdata_out, 32'hB);
      check("t3_gpio_out", gpio_out, 32'h3);
      bus_write(A_CTRL, 32'h2);
      bus_read(A_CTRL);     check("t3_cleared", sdata_out, 32'h3);

      // Reset mid-operation aborts everything, then a fresh op runs
      bus_write(A_CTRL, 32'h1);
      repeat (19) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t4_gpio_out", gpio_out, 32'h0);
      check("t4_sdata_out", sdata_out, 32'h0);
      bus_read(A_W);    check("t4_w", sdata_out, 32'h0);
      bus_read(A_L);    check("t4_l", sdata_out, 32'h0);
      bus_read(A_CTRL); check("t4_status", sdata_out, 32'h3);
      bus_read(A_A1);   check("t4_a1", sdata_out, 32'h0);
      bus_write(A_A1, 32'h7);
      bus_write(A_A2, 32'h9);
      bus_write(A_CTRL, 32'h1);
      repeat (60) @(negedge clk);
      bus_read(A_W);    check("t4_fresh_w", sdata_out, 32'h3F);
      bus_read(A_L);    check("t4_fresh_l", sdata_out, 32'h6);
      check("t4_fresh_gpio_out", gpio_out, 32'h1);
      check("t4_gpio_out8", gpio_out8, 32'h1);

      // Narrow instance: 25-cycle latency, operand write while busy has no effect
      bus_write(A_A1, 32'hFF);
      bus_write(A_A2, 32'hFF);
      bus_write(A_CTRL, 32'h1);
      bus_write(A_A1, 32'h1);
      repeat (22) @(negedge clk);
      check("t5_before_done8", gpio_out8, 32'h1);
      @(negedge clk);
      check("t5_at_done8", gpio_out8, 32'h2);
      bus_read(A_W);    check("t5_w8", sdata_out8, 32'hFE01);
      bus_read(A_L);    check("t5_l8", sdata_out8, 32'h8);
      bus_read(A_CTRL); check("t5_status8", sdata_out8, 32'h3);
      repeat (40) @(negedge clk);
      bus_read(A_W);    check("t5_w_wide", sdata_out, 32'hFE01);
      bus_read(A_CTRL); check("t5_status_wide", sdata_out, 32'h3);

      // Input capture holds after latch drops; unmapped read returns 0
      @(negedge clk);
      gpio_in = 32'hA5A5A5A5; gpio_latch = 1'b1;
      @(negedge clk);
      gpio_latch = 1'b0; gpio_in = 32'h12345678;
      repeat (2) @(negedge clk);
      check("t6_insp", gpio_in_s_insp, 32'hA5A5A5A5);
      bus_read(A_W);    check("t6_w_again", sdata_out, 32'hFE01);
      bus_read(16'h0400); check("t6_unmapped", sdata_out, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
